// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR line-buffer front end.
// LINES is the number of stored image lines feeding the vertical window.
package fir_pkg;

  localparam int PIX_W       = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int LINES       = KERNEL_SIZE - 1;
  localparam int LINE_SEL_W  = $clog2(LINES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Index of the RAM that holds the line written 'age' rows before 'base'.
  function automatic logic [LINE_SEL_W-1:0] line_sel(input logic [LINE_SEL_W-1:0] base,
                                                      input int age);
    return base - LINE_SEL_W'(age);
  endfunction

endpackage

// File: rtl/fir_line_ram.sv
// Single-port, read-first synchronous RAM holding one image line.
// Written so synthesis maps it onto block RAM.
module fir_line_ram #(
  parameter  int DEPTH  = 640,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would prevent block-RAM mapping,
  // and downstream valid gating makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/fir_line_buffer.sv
// Raster-to-column front end: buffers four previous lines and emits one
// registered 5-pixel vertical column per accepted pixel once streaming.
module fir_line_buffer #(
  parameter int PIX_W = fir_pkg::PIX_W,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel0,
  output logic [PIX_W-1:0] pixel1,
  output logic [PIX_W-1:0] pixel2,
  output logic [PIX_W-1:0] pixel3,
  output logic [PIX_W-1:0] pixel4,
  output logic             out_eol,
  output logic             out_eof
);

  import fir_pkg::*;

  state_e                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d, col_eff;
  logic [ROW_W-1:0]       row_q, row_d, row_eff;
  logic [LINE_SEL_W-1:0]  sel_q, sel_d, rd_sel_q;
  logic                   sof_acc, take, last_col, last_row;
  logic                   valid_d, eol_d, eof_d;
  logic                   valid_q, eol_q, eof_q, fresh_q;
  logic [PIX_W-1:0]       pix4_q;
  logic [PIX_W-1:0]       ram_dout [LINES];
  logic [PIX_W-1:0]       tap      [LINES];
  logic [PIX_W-1:0]       hold_q   [LINES];
  logic [PIX_W-1:0]       col_out  [LINES];

  // An accepted sof restarts the frame, so it overrides the running counters.
  always_comb begin
    sof_acc  = in_valid & in_sof;
    take     = in_valid & ~rst & (sof_acc | (state_q != S_IDLE));
    col_eff  = sof_acc ? '0 : col_q;
    row_eff  = sof_acc ? '0 : row_q;
    last_col = (col_eff == COL_W'(IMG_W - 1));
    last_row = (row_eff == ROW_W'(IMG_H - 1));
  end

  // NOTE: every signal gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    if (take) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_eff + 1'b1;
        sel_d = sel_q + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      if (sof_acc) begin
        state_d = S_FILL;
      end else begin
        case (state_q)
          S_FILL: begin
            if (last_col && row_eff == ROW_W'(LINES - 1)) state_d = S_STREAM;
          end
          S_STREAM: begin
            valid_d = 1'b1;
            eol_d   = last_col;
            eof_d   = last_col & last_row;
            if (last_col && last_row) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Lines rotate through the RAMs instead of being copied between them: a
  // read-first single-port RAM cannot forward its read data to a neighbour in
  // the same cycle, and the rotation yields the same column for every line.
  for (genvar k = 0; k < LINES; k++) begin : g_line
    fir_line_ram #(
      .DEPTH (IMG_W),
      .WIDTH (PIX_W)
    ) u_ram (
      .clk  (clk),
      .we   (take && sel_q == LINE_SEL_W'(k)),
      .addr (col_eff),
      .din  (in_pixel),
      .dout (ram_dout[k])
    );
  end

  // tap[a] is the line a+1 rows above the pixel accepted last; the RAM being
  // written returns its old contents, which is the line four rows up.
  always_comb begin
    for (int a = 0; a < LINES; a++) begin
      tap[a]     = ram_dout[line_sel(rd_sel_q, a + 1)];
      col_out[a] = fresh_q ? tap[a] : hold_q[a];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      sel_q    <= '0;
      rd_sel_q <= '0;
      valid_q  <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      fresh_q  <= 1'b0;
      pix4_q   <= '0;
      for (int a = 0; a < LINES; a++) hold_q[a] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      fresh_q <= take;
      if (take) begin
        rd_sel_q <= sel_q;
        pix4_q   <= in_pixel;
      end
      // RAM read ports move on after an accept; keep the column stable.
      if (fresh_q) begin
        for (int a = 0; a < LINES; a++) hold_q[a] <= tap[a];
      end
    end
  end

  assign out_valid = valid_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign pixel4    = pix4_q;
  assign pixel3    = col_out[0];
  assign pixel2    = col_out[1];
  assign pixel1    = col_out[2];
  assign pixel0    = col_out[3];

endmodule

// File: tb/tb_fir_line_buffer.sv
// Self-checking bench for fir_line_buffer at IMG_W=8, IMG_H=6: table-driven
// frame vectors, hand-written corner sequences and a random run vs a line model.
module tb_fir_line_buffer;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof;
  logic [7:0] in_pixel;
  logic       out_valid, out_eol, out_eof;
  logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4;

  fir_line_buffer #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .pixel0    (pixel0),
    .pixel1    (pixel1),
    .pixel2    (pixel2),
    .pixel3    (pixel3),
    .pixel4    (pixel4),
    .out_eol   (out_eol),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_valid, n_eof;
  logic [39:0] first_col;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: each column keeps its own history of the last four
  // pixels written at that column, most recent first.
  bit          m_in_frame;
  int          m_row, m_col;
  logic [7:0]  m_hist [4][W];
  logic [39:0] m_held;
  bit          m_hold_ok;

  task automatic model_reset();
    m_in_frame = 0;
    m_row      = 0;
    m_col      = 0;
    m_held     = '0;
    m_hold_ok  = 1;
  endtask

  task automatic model_apply(input bit v, input bit s, input logic [7:0] p,
                             output bit ev, output bit eeol, output bit eeof,
                             output logic [39:0] epix, output bit cpix);
    ev   = 0;
    eeol = 0;
    eeof = 0;
    epix = m_held;
    cpix = m_hold_ok;
    if (v && (s || m_in_frame)) begin
      if (s) begin
        m_in_frame = 1;
        m_row      = 0;
        m_col      = 0;
      end
      ev   = (m_row >= 4);
      epix = {m_hist[3][m_col], m_hist[2][m_col], m_hist[1][m_col], m_hist[0][m_col], p};
      for (int k = 3; k > 0; k--) m_hist[k][m_col] = m_hist[k-1][m_col];
      m_hist[0][m_col] = p;
      eeol = ev && (m_col == W - 1);
      eeof = eeol && (m_row == H - 1);
      if (ev) m_held = epix;
      m_hold_ok = ev;
      cpix      = ev;
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row++;
        if (m_row == H) begin
          m_row      = 0;
          m_in_frame = 0;
        end
      end
    end
  endtask

  function automatic logic [39:0] dut_col();
    return {pixel0, pixel1, pixel2, pixel3, pixel4};
  endfunction

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    bit ev, eeol, eeof, cpix;
    logic [39:0] epix;
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    model_apply(v, s, p, ev, eeol, eeof, epix, cpix);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, ev);
    check("out_eol", out_eol, eeol);
    check("out_eof", out_eof, eeof);
    if (cpix) check("column", dut_col(), epix);
    if (out_valid) begin
      n_valid++;
      if (n_valid == 1) first_col = dut_col();
    end
    if (out_eof) n_eof++;
  endtask

  task automatic send_px(input int idx);
    step(1'b1, idx == 0, px(idx / W, idx % W));
  endtask

  task automatic do_reset(input bit v);
    rst      = 1'b1;
    in_valid = v;
    in_sof   = 1'b0;
    in_pixel = 8'h55;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_eol", out_eol, 1'b0);
    check("reset out_eof", out_eof, 1'b0);
    check("reset column", dut_col(), 40'h0);
    n_valid = 0;
    n_eof   = 0;
  endtask

  typedef struct {
    bit          v;
    bit          sof;
    logic [7:0]  pix;
    bit          exp_valid;
    bit          exp_eol;
    bit          exp_eof;
    logic [39:0] exp_col;
  } vec_t;

  vec_t tbl [5 + W * H];

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 40'h0};
    for (int i = 0; i < W * H; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      tbl[5 + i].v         = 1'b1;
      tbl[5 + i].sof       = (i == 0);
      tbl[5 + i].pix       = px(r, c);
      tbl[5 + i].exp_valid = (r >= 4);
      tbl[5 + i].exp_eol   = (r >= 4) && (c == W - 1);
      tbl[5 + i].exp_eof   = (r == H - 1) && (c == W - 1);
      tbl[5 + i].exp_col   = (r >= 4) ?
          {px(r - 4, c), px(r - 3, c), px(r - 2, c), px(r - 1, c), px(r, c)} : 40'h0;
    end

    for (int k = 0; k < 4; k++)
      for (int c = 0; c < W; c++) m_hist[k][c] = '0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // Continuous frame preceded by pre-sof garbage, from the vector table.
    for (int i = 0; i < 5 + W * H; i++) begin
      step(tbl[i].v, tbl[i].sof, tbl[i].pix);
      check("tbl valid", out_valid, tbl[i].exp_valid);
      check("tbl eol", out_eol, tbl[i].exp_eol);
      check("tbl eof", out_eof, tbl[i].exp_eof);
      if (tbl[i].exp_valid) check("tbl column", dut_col(), tbl[i].exp_col);
    end
    check("frame valid count", n_valid, 16);
    check("frame eof count", n_eof, 1);
    check("frame first column", first_col, 40'h0010203040);
    repeat (2) step(1'b0, 1'b0, 8'h00);

    // Stalls in the middle of row 4.
    do_reset(1'b0);
    for (int i = 0; i <= 4 * W + 3; i++) send_px(i);
    repeat (3) begin
      step(1'b0, 1'b0, 8'hEE);
      check("stall out_valid", out_valid, 1'b0);
    end
    send_px(4 * W + 4);
    check("post-stall column", dut_col(), 40'h0414243444);
    for (int i = 4 * W + 5; i < W * H; i++) send_px(i);
    check("stall valid count", n_valid, 16);

    // Abort at row 5, column 2 with a new sof.
    do_reset(1'b0);
    for (int i = 0; i < 5 * W + 2; i++) send_px(i);
    n_valid = 0;
    for (int i = 0; i < W * H; i++) begin
      send_px(i);
      if (i == 4 * W) check("abort first valid", n_valid, 1);
    end
    check("abort first column", first_col, 40'h0010203040);
    check("abort valid count", n_valid, 16);

    // Reset asserted at row 4, column 5, then accepts without sof.
    do_reset(1'b0);
    for (int i = 0; i < 4 * W + 5; i++) send_px(i);
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, px(4, i % W));
    check("post-reset valid count", n_valid, 0);
    check("post-reset column", dut_col(), 40'h0);

    // Back-to-back frames.
    do_reset(1'b0);
    for (int i = 0; i < W * H; i++) send_px(i);
    n_valid = 0;
    for (int i = 0; i < W * H; i++) send_px(i);
    check("b2b frame2 first column", first_col, 40'h0010203040);
    check("b2b frame2 valid count", n_valid, 16);
    check("b2b eof count", n_eof, 2);

    // sof arriving on the last pixel of a frame wins.
    do_reset(1'b0);
    for (int i = 0; i < W * H - 1; i++) send_px(i);
    step(1'b1, 1'b1, 8'h00);
    check("sof-on-last eof", out_eof, 1'b0);
    for (int i = 1; i < W * H; i++) send_px(i);
    check("sof-on-last valid count", n_valid, 31);
    check("sof-on-last eof count", n_eof, 1);

    // Random pixels, gaps, garbage and occasional aborts against the model.
    do_reset(1'b0);
    for (int f = 0; f < 8; f++) begin
      int idx, guard;
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 8'($urandom));
      step(1'b1, 1'b1, 8'($urandom));
      idx   = 1;
      guard = 0;
      while (idx < W * H && guard < 2000) begin
        guard++;
        if ($urandom_range(0, 3) == 0) step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
        else if ($urandom_range(0, 99) == 0) begin
          step(1'b1, 1'b1, 8'($urandom));
          idx = 1;
        end else begin
          step(1'b1, 1'b0, 8'($urandom));
          idx++;
        end
      end
      check("random frame bounded", guard < 2000, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
